// File: rtl/p_uart_recv.sv
//==============================================================================
// Module      : p_uart_recv
// Description : Packet UART receiver. Deserialises 8N1 bytes from uart_rxd
//               and packs 16 consecutive bytes into a 128-bit word, byte k in
//               uart_data[8k+7:8k]. A full packet is presented with a
//               one-cycle uart_done pulse.
// Ports       : sys_clk     - system clock
//               sys_rst     - asynchronous active-high reset
//               uart_rxd    - serial input, idle high, asynchronous
//               uart_done   - one-cycle pulse, uart_data holds a new packet
//               uart_data   - last complete packet, byte 0 in [7:0]
//               rx_busy     - high while a byte frame is in progress
//               rx_byte_cnt - bytes of the current packet received (0..15)
//               frame_err   - one-cycle pulse, bad stop bit, byte dropped
//               rx_timeout  - one-cycle pulse, partial packet discarded
// Options     : define P_UART_RECV_TIMEOUT_EN to discard partial packets
//               after TIMEOUT_BITS idle bit-times (otherwise rx_timeout = 0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module p_uart_recv #(
    parameter int CLK_FREQ     = 50000000,
    parameter int UART_BPS     = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         uart_rxd,
    output logic         uart_done,
    output logic [127:0] uart_data,
    output logic         rx_busy,
    output logic [3:0]   rx_byte_cnt,
    output logic         frame_err,
    output logic         rx_timeout
);

    localparam int c_BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int c_CNT_W   = (c_BPS_CNT > 1) ? $clog2(c_BPS_CNT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(c_BPS_CNT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_BPS_CNT / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rxd_d0;
    logic                 r_rxd_d1;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [127:0]         r_shadow;
    logic                 w_start_edge;
    logic                 w_sample;
    logic                 w_stop_ok;
    logic                 w_stop_bad;
    logic                 w_to_fire;

    // Two-flop synchroniser; idles high so reset release is not a start edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rxd_d0 <= 1'b1;
            r_rxd_d1 <= 1'b1;
        end else begin
            r_rxd_d0 <= uart_rxd;
            r_rxd_d1 <= r_rxd_d0;
        end
    end

    assign w_start_edge = r_rxd_d1 & ~r_rxd_d0;
    assign w_sample     = (r_clk_cnt == c_CNT_HALF);
    assign w_stop_ok    = (r_state == STOP) && w_sample &&  r_rxd_d0;
    assign w_stop_bad   = (r_state == STOP) && w_sample && !r_rxd_d0;
    assign rx_busy      = (r_state != IDLE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_start_edge) w_state_nxt = START;
            // A start bit that is high again at mid-bit was a glitch.
            START: if (w_sample) w_state_nxt = r_rxd_d0 ? IDLE : DATA;
            DATA:  if (w_sample && (r_bit_cnt == 3'd7)) w_state_nxt = STOP;
            // Leave at mid stop bit so the next start edge is not missed.
            STOP:  if (w_sample) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bit-period counter, held at 0 in IDLE so it is phase-locked to the
    // start edge, then free-running across bit boundaries.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_clk_cnt <= '0;
        end else if ((r_state == IDLE) || (r_clk_cnt == c_CNT_MAX)) begin
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (r_state == START) begin
            r_bit_cnt <= 3'd0;
        end else if ((r_state == DATA) && w_sample) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= {r_rxd_d0, r_shift[7:1]};
        end
    end

`ifdef P_UART_RECV_TIMEOUT_EN
    localparam int c_TO_LIMIT = TIMEOUT_BITS * c_BPS_CNT;
    localparam int c_TO_W     = $clog2(c_TO_LIMIT + 1);

    logic [c_TO_W-1:0] r_to_cnt;

    assign w_to_fire = (r_state == IDLE) && (rx_byte_cnt != 4'd0) &&
                       !w_start_edge && (r_to_cnt == c_TO_W'(c_TO_LIMIT));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_to_cnt <= '0;
        end else if (w_start_edge || (r_state != IDLE) ||
                     (rx_byte_cnt == 4'd0) || w_to_fire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) rx_timeout <= 1'b0;
        else         rx_timeout <= w_to_fire;
    end
`else
    assign w_to_fire  = 1'b0;
    // Constant 0; TIMEOUT_BITS only has meaning when the timeout is built.
    assign rx_timeout = (TIMEOUT_BITS < 0);
`endif

    // Packet assembly. The completing byte is merged straight into
    // uart_data so the word and its done pulse appear together.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_shadow    <= '0;
            uart_data   <= '0;
            uart_done   <= 1'b0;
            frame_err   <= 1'b0;
            rx_byte_cnt <= 4'd0;
        end else begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            if (w_stop_ok) begin
                r_shadow[{rx_byte_cnt, 3'b000} +: 8] <= r_shift;
                rx_byte_cnt <= rx_byte_cnt + 4'd1;
                if (rx_byte_cnt == 4'd15) begin
                    uart_data <= {r_shift, r_shadow[119:0]};
                    uart_done <= 1'b1;
                end
            end else if (w_stop_bad) begin
                frame_err <= 1'b1;
            end else if (w_to_fire) begin
                r_shadow    <= '0;
                rx_byte_cnt <= 4'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_p_uart_recv.sv
//==============================================================================
// Module      : tb_p_uart_recv
// Description : Directed self-checking bench for p_uart_recv with
//               BPS_CNT = 16 (CLK_FREQ = 16, UART_BPS = 1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_p_uart_recv;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         uart_rxd = 1'b1;
    logic         uart_done;
    logic [127:0] uart_data;
    logic         rx_busy;
    logic [3:0]   rx_byte_cnt;
    logic         frame_err;
    logic         rx_timeout;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int n_done = 0;
    int n_ferr = 0;
    int n_to   = 0;
    int d0, f0, t0;

    p_uart_recv #(
        .CLK_FREQ    (16),
        .UART_BPS    (1),
        .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_rxd   (uart_rxd),
        .uart_done  (uart_done),
        .uart_data  (uart_data),
        .rx_busy    (rx_busy),
        .rx_byte_cnt(rx_byte_cnt),
        .frame_err  (frame_err),
        .rx_timeout (rx_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters sampled on the inactive edge; a pulse that lasts two
    // cycles counts twice.
    always @(negedge sys_clk) begin
        if (uart_done)  n_done++;
        if (frame_err)  n_ferr++;
        if (rx_timeout) n_to++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(16);
        end
        uart_rxd = stop_bit;
        tick(16);
        uart_rxd = 1'b1;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b1);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_done",  uart_done,   1'b0);
        chk("rst_data",  uart_data,   128'h0);
        chk("rst_busy",  rx_busy,     1'b0);
        chk("rst_cnt",   rx_byte_cnt, 4'd0);
        chk("rst_ferr",  frame_err,   1'b0);
        chk("rst_to",    rx_timeout,  1'b0);
        sys_rst = 1'b0;
        tick(5);

        // Packet 0x00..0x0F
        d0 = n_done; f0 = n_ferr;
        send_bytes(8'h00, 16);
        tick(4);
        chk("pkt0_done", n_done - d0, 1);
        chk("pkt0_data", uart_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("pkt0_cnt",  rx_byte_cnt, 4'd0);
        chk("pkt0_ferr", n_ferr - f0, 0);

        // Start-bit glitch of 4 clocks
        uart_rxd = 1'b0;
        tick(4);
        chk("glitch_busy_hi", rx_busy, 1'b1);
        uart_rxd = 1'b1;
        tick(16);
        chk("glitch_busy_lo", rx_busy, 1'b0);
        chk("glitch_cnt",     rx_byte_cnt, 4'd0);
        chk("glitch_ferr",    n_ferr - f0, 0);

        // Bad stop bit, then a full packet
        send_byte(8'h55, 1'b0);
        tick(32);
        chk("ferr_pulse", n_ferr - f0, 1);
        chk("ferr_cnt",   rx_byte_cnt, 4'd0);
        chk("ferr_hold",  uart_data, 128'h0F0E0D0C0B0A09080706050403020100);
        d0 = n_done;
        send_bytes(8'hA0, 16);
        tick(4);
        chk("pktA_done", n_done - d0, 1);
        chk("pktA_data", uart_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);

        // Reset during bit 3 of byte 5
        send_bytes(8'h10, 5);
        chk("part_cnt",  rx_byte_cnt, 4'd5);
        chk("part_hold", uart_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        uart_rxd = 1'b0; tick(16);
        uart_rxd = 1'b1; tick(16);
        uart_rxd = 1'b0; tick(16);
        uart_rxd = 1'b1; tick(16);
        uart_rxd = 1'b0; tick(8);
        chk("mid_busy", rx_busy, 1'b1);
        sys_rst = 1'b1;
        #1;
        chk("mrst_data", uart_data,   128'h0);
        chk("mrst_cnt",  rx_byte_cnt, 4'd0);
        chk("mrst_busy", rx_busy,     1'b0);
        chk("mrst_done", uart_done,   1'b0);
        chk("mrst_ferr", frame_err,   1'b0);
        chk("mrst_to",   rx_timeout,  1'b0);
        uart_rxd = 1'b1;
        tick(3);
        sys_rst = 1'b0;
        tick(20);
        d0 = n_done;
        send_bytes(8'h10, 16);
        tick(4);
        chk("pkt1_done", n_done - d0, 1);
        chk("pkt1_data", uart_data, 128'h1F1E1D1C1B1A19181716151413121110);

        // Idle gap after a partial packet
        d0 = n_done; t0 = n_to;
        send_bytes(8'hC0, 3);
        tick(340);
`ifdef P_UART_RECV_TIMEOUT_EN
        chk("to_pulse", n_to - t0, 1);
        chk("to_cnt",   rx_byte_cnt, 4'd0);
        send_bytes(8'hC0, 16);
`else
        chk("to_pulse", n_to - t0, 0);
        chk("to_cnt",   rx_byte_cnt, 4'd3);
        send_bytes(8'hC3, 13);
`endif
        tick(4);
        chk("pktC_done", n_done - d0, 1);
        chk("pktC_data", uart_data, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);

        // Two packets back to back
        d0 = n_done; f0 = n_ferr;
        send_bytes(8'h00, 16);
        chk("b2b_first", uart_data, 128'h0F0E0D0C0B0A09080706050403020100);
        send_bytes(8'hF0, 16);
        tick(4);
        chk("b2b_done", n_done - d0, 2);
        chk("b2b_data", uart_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        chk("b2b_ferr", n_ferr - f0, 0);
        chk("b2b_cnt",  rx_byte_cnt, 4'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
